// File: rtl/gb_pool_rsp.sv
// Global-buffer responder for the POOL read protocol: two ping-pong psum banks,
// PE side fills one while POOL drains the other. Optional address range check: GB_POOL_ADDR_CHK_EN.
module gb_pool_rsp #(
  parameter int PSUM_WIDTH = 24,
  parameter int NUM_PEB    = 16,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          PEGB_val,
  input  logic [ADDR_WIDTH-1:0]         PEGB_addr,
  input  logic [PSUM_WIDTH*NUM_PEB-1:0] PEGB_data,
  input  logic                          PEGB_last,
  output logic                          GBPE_rdy,
  input  logic                          POOLGB_rdy,
  input  logic [ADDR_WIDTH-1:0]         POOLGB_addr,
  input  logic                          POOLGB_fnh,
  output logic                          GBPOOL_val,
  output logic [PSUM_WIDTH*NUM_PEB-1:0] GBPOOL_data,
`ifdef GB_POOL_ADDR_CHK_EN
  output logic                          GBPOOL_bank_rdy,
  output logic                          GBPOOL_err
`else
  output logic                          GBPOOL_bank_rdy
`endif
);

  localparam int DW    = PSUM_WIDTH * NUM_PEB;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {
    B_EMPTY    = 2'd0,
    B_FILLING  = 2'd1,
    B_FULL     = 2'd2,
    B_DRAINING = 2'd3
  } bank_state_t;

  bank_state_t state_q [2];
  bank_state_t state_d [2];
  logic        wr_ptr, wr_ptr_d;
  logic        rd_ptr, rd_ptr_d;
  logic        fill_rdy_d;

  logic [DW-1:0] mem [2][DEPTH];
  logic [DW-1:0] rd_word;

  logic wr_fire, rd_fire, fnh_fire;

  assign wr_fire  = PEGB_val && GBPE_rdy;
  assign rd_fire  = POOLGB_rdy && (state_q[rd_ptr] == B_DRAINING);
  assign fnh_fire = POOLGB_fnh && (state_q[rd_ptr] == B_DRAINING);

  assign GBPOOL_bank_rdy = (state_q[rd_ptr] == B_FULL) || (state_q[rd_ptr] == B_DRAINING);

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      state_d[b] = (state_q[b] == B_FULL) ? B_DRAINING : state_q[b];
    end
    wr_ptr_d = wr_ptr;
    rd_ptr_d = rd_ptr;

    // The fill bank is never FULL when a write is accepted, so this cannot
    // collide with the FULL->DRAINING promotion above.
    if (wr_fire) begin
      state_d[wr_ptr] = PEGB_last ? B_FULL : B_FILLING;
      if (PEGB_last) wr_ptr_d = ~wr_ptr;
    end

    if (fnh_fire) begin
      state_d[rd_ptr] = B_EMPTY;
      rd_ptr_d        = ~rd_ptr;
    end

    fill_rdy_d = (state_d[wr_ptr_d] == B_EMPTY) || (state_d[wr_ptr_d] == B_FILLING);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) state_q[b] <= B_EMPTY;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      GBPE_rdy <= 1'b0;
    end else begin
      for (int b = 0; b < 2; b++) state_q[b] <= state_d[b];
      wr_ptr   <= wr_ptr_d;
      rd_ptr   <= rd_ptr_d;
      GBPE_rdy <= fill_rdy_d;
    end
  end

  // NOTE: the psum storage is deliberately left out of reset; only the control state is reset.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_ptr][PEGB_addr] <= PEGB_data;
  end

`ifdef GB_POOL_ADDR_CHK_EN
  logic [ADDR_WIDTH-1:0] max_wr_q [2];
  logic                  rd_oob;

  assign rd_oob  = POOLGB_addr > max_wr_q[rd_ptr];
  assign rd_word = rd_oob ? '0 : mem[rd_ptr][POOLGB_addr];

  // The first write into an EMPTY bank restarts the high-water mark for that fill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) max_wr_q[b] <= '0;
      GBPOOL_err <= 1'b0;
    end else begin
      if (wr_fire && ((state_q[wr_ptr] == B_EMPTY) || (PEGB_addr > max_wr_q[wr_ptr]))) begin
        max_wr_q[wr_ptr] <= PEGB_addr;
      end
      if (rd_fire && rd_oob) GBPOOL_err <= 1'b1;
    end
  end
`else
  assign rd_word = mem[rd_ptr][POOLGB_addr];
`endif

  // Read data register holds its value between accepted reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      GBPOOL_val  <= 1'b0;
      GBPOOL_data <= '0;
    end else begin
      GBPOOL_val <= rd_fire;
      if (rd_fire) GBPOOL_data <= rd_word;
    end
  end

endmodule

// File: tb/tb_gb_pool_rsp.sv
// Directed-plus-random bench for gb_pool_rsp with a word-level reference model of both banks.
module tb_gb_pool_rsp;
  localparam int PW = 24;
  localparam int NP = 16;
  localparam int AW = 8;
  localparam int DW = PW * NP;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          pegb_val, pegb_last, poolgb_rdy, poolgb_fnh;
  logic [AW-1:0] pegb_addr, poolgb_addr;
  logic [DW-1:0] pegb_data;
  logic          gbpe_rdy, gbpool_val, gbpool_bank_rdy;
  logic [DW-1:0] gbpool_data;
`ifdef GB_POOL_ADDR_CHK_EN
  logic          gbpool_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: plain word arrays per bank plus which bank each side targets.
  logic [DW-1:0] exp_mem [2][256];
  logic [DW-1:0] last_data;
  int wr_b, rd_b;

  gb_pool_rsp #(.PSUM_WIDTH(PW), .NUM_PEB(NP), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .PEGB_val(pegb_val), .PEGB_addr(pegb_addr), .PEGB_data(pegb_data), .PEGB_last(pegb_last),
    .GBPE_rdy(gbpe_rdy),
    .POOLGB_rdy(poolgb_rdy), .POOLGB_addr(poolgb_addr), .POOLGB_fnh(poolgb_fnh),
    .GBPOOL_val(gbpool_val), .GBPOOL_data(gbpool_data),
`ifdef GB_POOL_ADDR_CHK_EN
    .GBPOOL_bank_rdy(gbpool_bank_rdy), .GBPOOL_err(gbpool_err)
`else
    .GBPOOL_bank_rdy(gbpool_bank_rdy)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  // Writes addresses 0..n-1 into the current fill bank, last on n-1.
  task automatic fill(input int n);
    for (int i = 0; i < n; i++) begin
      pegb_val  = 1'b1;
      pegb_addr = AW'(i);
      pegb_data = rand_word();
      pegb_last = (i == n - 1);
      exp_mem[wr_b][i] = pegb_data;
      tick();
    end
    pegb_val  = 1'b0;
    pegb_last = 1'b0;
    wr_b = 1 - wr_b;
  endtask

  // Back-to-back reads of lo..hi from the drain bank, checked one cycle after each request.
  task automatic read_range(input int lo, input int hi);
    for (int a = lo; a <= hi; a++) begin
      poolgb_rdy  = 1'b1;
      poolgb_addr = AW'(a);
      tick();
      check("rd_val", DW'(gbpool_val), DW'(1));
      check("rd_data", gbpool_data, exp_mem[rd_b][a]);
      last_data = exp_mem[rd_b][a];
    end
    poolgb_rdy = 1'b0;
    tick();
    check("rd_idle_val", DW'(gbpool_val), DW'(0));
    check("rd_hold_data", gbpool_data, last_data);
  endtask

  task automatic finish_bank();
    poolgb_fnh = 1'b1;
    tick();
    poolgb_fnh = 1'b0;
    rd_b = 1 - rd_b;
  endtask

  initial begin
    int w, r, waddr, raddr;
    logic [DW-1:0] wdata, exp_rd;

    rst_n = 1'b0;
    pegb_val = 0; pegb_addr = '0; pegb_data = '0; pegb_last = 0;
    poolgb_rdy = 0; poolgb_addr = '0; poolgb_fnh = 0;
    wr_b = 0; rd_b = 0; last_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_gbpe_rdy", DW'(gbpe_rdy), DW'(0));
    check("rst_val", DW'(gbpool_val), DW'(0));
    check("rst_data", gbpool_data, DW'(0));
    check("rst_bank_rdy", DW'(gbpool_bank_rdy), DW'(0));
`ifdef GB_POOL_ADDR_CHK_EN
    check("rst_err", DW'(gbpool_err), DW'(0));
`endif
    rst_n = 1'b1;
    tick();
    check("idle_gbpe_rdy", DW'(gbpe_rdy), DW'(1));
    check("idle_bank_rdy", DW'(gbpool_bank_rdy), DW'(0));

    // Read request with both banks empty is ignored.
    poolgb_rdy = 1'b1;
    poolgb_addr = 8'd3;
    tick();
    check("empty_rd_val", DW'(gbpool_val), DW'(0));
    poolgb_rdy = 1'b0;

    // Full 256-word bank, drained back-to-back.
    fill(256);
    check("full_bank_rdy", DW'(gbpool_bank_rdy), DW'(1));
    check("full_gbpe_rdy", DW'(gbpe_rdy), DW'(1));
    tick();
    read_range(0, 255);
    finish_bank();
    check("fnh_bank_rdy", DW'(gbpool_bank_rdy), DW'(0));

    // Fill both banks; the fill side must stall and drop writes.
    fill(8);
    fill(8);
    check("both_full_gbpe_rdy", DW'(gbpe_rdy), DW'(0));
    for (int i = 0; i < 8; i++) begin
      pegb_val  = 1'b1;
      pegb_addr = AW'(i);
      pegb_data = rand_word();
      pegb_last = (i == 7);
      tick();
      check("stall_gbpe_rdy", DW'(gbpe_rdy), DW'(0));
    end
    pegb_val = 1'b0;
    pegb_last = 1'b0;
    read_range(0, 7);

    // Read and fnh in the same cycle, then a read from the new drain bank.
    poolgb_rdy  = 1'b1;
    poolgb_addr = 8'd5;
    poolgb_fnh  = 1'b1;
    tick();
    poolgb_fnh = 1'b0;
    check("fnh_rd_val", DW'(gbpool_val), DW'(1));
    check("fnh_rd_old_bank", gbpool_data, exp_mem[rd_b][5]);
    check("fnh_gbpe_rdy", DW'(gbpe_rdy), DW'(1));
    rd_b = 1 - rd_b;
    tick();
    check("post_fnh_rd_val", DW'(gbpool_val), DW'(1));
    check("post_fnh_rd_new_bank", gbpool_data, exp_mem[rd_b][5]);
    last_data = exp_mem[rd_b][5];
    poolgb_rdy = 1'b0;

    // Random concurrent fill and drain on distinct banks.
    for (int c = 0; c < 60; c++) begin
      w     = $urandom_range(0, 1);
      r     = $urandom_range(0, 1);
      waddr = $urandom_range(0, 255);
      raddr = $urandom_range(0, 7);
      wdata = rand_word();
      pegb_val    = w[0];
      pegb_addr   = AW'(waddr);
      pegb_data   = wdata;
      pegb_last   = 1'b0;
      poolgb_rdy  = r[0];
      poolgb_addr = AW'(raddr);
      exp_rd = r[0] ? exp_mem[rd_b][raddr] : last_data;
      if (w[0]) exp_mem[wr_b][waddr] = wdata;
      tick();
      check("mix_val", DW'(gbpool_val), DW'(r));
      check("mix_data", gbpool_data, exp_rd);
      last_data = exp_rd;
    end
    poolgb_rdy = 1'b0;
    pegb_val  = 1'b1;
    pegb_addr = 8'd255;
    pegb_data = rand_word();
    pegb_last = 1'b1;
    exp_mem[wr_b][255] = pegb_data;
    tick();
    pegb_val = 1'b0;
    pegb_last = 1'b0;
    wr_b = 1 - wr_b;
    finish_bank();
    for (int c = 0; c < 16; c++) begin
      raddr = (c == 0) ? 255 : $urandom_range(0, 255);
      poolgb_rdy  = 1'b1;
      poolgb_addr = AW'(raddr);
      tick();
      check("mix_drain_val", DW'(gbpool_val), DW'(1));
      check("mix_drain_data", gbpool_data, exp_mem[rd_b][raddr]);
    end
    poolgb_rdy = 1'b0;
    finish_bank();
    check("all_empty_bank_rdy", DW'(gbpool_bank_rdy), DW'(0));

    // fnh with nothing draining is ignored: the next bank still drains from the same pointer.
    poolgb_fnh = 1'b1;
    tick();
    poolgb_fnh = 1'b0;
    check("stray_fnh_bank_rdy", DW'(gbpool_bank_rdy), DW'(0));
    fill(4);
    tick();
    check("small_bank_rdy", DW'(gbpool_bank_rdy), DW'(1));

    // Asynchronous reset while a read response is in flight.
    poolgb_rdy  = 1'b1;
    poolgb_addr = 8'd2;
    tick();
    check("pre_rst_val", DW'(gbpool_val), DW'(1));
    check("pre_rst_data", gbpool_data, exp_mem[rd_b][2]);
    rst_n = 1'b0;
    #1;
    check("async_rst_val", DW'(gbpool_val), DW'(0));
    check("async_rst_bank_rdy", DW'(gbpool_bank_rdy), DW'(0));
    check("async_rst_gbpe_rdy", DW'(gbpe_rdy), DW'(0));
    poolgb_rdy = 1'b0;
    tick();
    rst_n = 1'b1;
    wr_b = 0;
    rd_b = 0;
    tick();
    check("rerst_gbpe_rdy", DW'(gbpe_rdy), DW'(1));
    check("rerst_bank_rdy", DW'(gbpool_bank_rdy), DW'(0));
    poolgb_rdy = 1'b1;
    tick();
    check("rerst_rd_val", DW'(gbpool_val), DW'(0));
    poolgb_rdy = 1'b0;

`ifdef GB_POOL_ADDR_CHK_EN
    fill(10);
    tick();
    poolgb_rdy  = 1'b1;
    poolgb_addr = 8'd12;
    tick();
    check("oob_val", DW'(gbpool_val), DW'(1));
    check("oob_data", gbpool_data, DW'(0));
    check("oob_err", DW'(gbpool_err), DW'(1));
    poolgb_addr = 8'd3;
    tick();
    check("inb_data", gbpool_data, exp_mem[rd_b][3]);
    check("err_sticky", DW'(gbpool_err), DW'(1));
    poolgb_rdy = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
